// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus signals of apb_master_bridge, grouped as one interface.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb_master_bridge_if #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32
);
    logic                      cmd_valid_in;
    logic                      cmd_ready_out;
    logic                      cmd_write_in;
    logic [APB_ADDR_WIDTH-1:0] cmd_addr_in;
    logic [APB_DATA_WIDTH-1:0] cmd_wdata_in;

    logic                      rsp_valid_out;
    logic                      rsp_ready_in;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_out;
    logic                      rsp_err_out;
    logic                      rsp_timeout_out;

    logic [APB_ADDR_WIDTH-1:0] apb_addr_out;
    logic                      apb_psel_out;
    logic                      apb_penable_out;
    logic                      apb_write_out;
    logic [APB_DATA_WIDTH-1:0] apb_wdata_out;
    logic [APB_DATA_WIDTH-1:0] apb_rdata_in;
    logic                      apb_ready_in;
    logic                      apb_slverr_in;

    modport master (
        input  cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in,
        output cmd_ready_out,
        output rsp_valid_out, rsp_rdata_out, rsp_err_out, rsp_timeout_out,
        input  rsp_ready_in,
        output apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out, apb_wdata_out,
        input  apb_rdata_in, apb_ready_in, apb_slverr_in
    );

    modport slave (
        output cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in,
        input  cmd_ready_out,
        input  rsp_valid_out, rsp_rdata_out, rsp_err_out, rsp_timeout_out,
        output rsp_ready_in,
        input  apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out, apb_wdata_out,
        output apb_rdata_in, apb_ready_in, apb_slverr_in
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB master bridge (IDLE/SETUP/ACCESS/RESP).
// Optional access-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLE  = 6
) (
    input  logic                 apb_clk_in,
    input  logic                 apb_rst_in,
    apb_master_bridge_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic                      psel_r, psel_s;
    logic                      penable_r, penable_s;
    logic                      write_r, write_s;
    logic [APB_ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [APB_DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic                      rsp_valid_r, rsp_valid_s;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
    logic                      rsp_err_r, rsp_err_s;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLE + 1);

    logic [CNT_W-1:0]          cnt_r, cnt_s;
    logic                      rsp_timeout_r, rsp_timeout_s;
    logic                      expire_s;

    // This ACCESS cycle is the TIMEOUT_CYCLE-th one seen with the slave not ready.
    assign expire_s = ((cnt_r + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLE));
`endif

    // Next state and next value of every registered output.
    always_comb begin
        state_s     = state_r;
        psel_s      = psel_r;
        penable_s   = penable_r;
        write_s     = write_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_s         = cnt_r;
        rsp_timeout_s = rsp_timeout_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid_in) begin
                    state_s   = SETUP;
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                    write_s   = bus.cmd_write_in;
                    addr_s    = bus.cmd_addr_in;
                    wdata_s   = bus.cmd_wdata_in;
                end else begin
                    state_s   = IDLE;
                end
            end
            SETUP: begin
                state_s   = ACCESS;
                penable_s = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_s     = {CNT_W{1'b0}};
`endif
            end
            ACCESS: begin
                // A ready slave always completes, even on the cycle the timer expires.
                if (bus.apb_ready_in) begin
                    state_s     = RESP;
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = write_r ? {APB_DATA_WIDTH{1'b0}} : bus.apb_rdata_in;
                    rsp_err_s   = bus.apb_slverr_in;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_timeout_s = 1'b0;
                end else if (expire_s) begin
                    state_s       = RESP;
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = {APB_DATA_WIDTH{1'b0}};
                    rsp_err_s     = 1'b1;
                    rsp_timeout_s = 1'b1;
                    cnt_s         = cnt_r + CNT_W'(1);
                end else begin
                    state_s = ACCESS;
                    cnt_s   = cnt_r + CNT_W'(1);
                end
`else
                end else begin
                    state_s = ACCESS;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready_in) begin
                    state_s     = IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    state_s     = RESP;
                end
            end
            default: begin
                state_s     = IDLE;
                psel_s      = 1'b0;
                penable_s   = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge apb_clk_in) begin
        if (apb_rst_in) begin
            state_r     <= IDLE;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            write_r     <= 1'b0;
            addr_r      <= {APB_ADDR_WIDTH{1'b0}};
            wdata_r     <= {APB_DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {APB_DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_r         <= {CNT_W{1'b0}};
            rsp_timeout_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            psel_r      <= psel_s;
            penable_r   <= penable_s;
            write_r     <= write_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_r         <= cnt_s;
            rsp_timeout_r <= rsp_timeout_s;
`endif
        end
    end

    assign bus.cmd_ready_out   = (state_r == IDLE);
    assign bus.apb_psel_out    = psel_r;
    assign bus.apb_penable_out = penable_r;
    assign bus.apb_write_out   = write_r;
    assign bus.apb_addr_out    = addr_r;
    assign bus.apb_wdata_out   = wdata_r;
    assign bus.rsp_valid_out   = rsp_valid_r;
    assign bus.rsp_rdata_out   = rsp_rdata_r;
    assign bus.rsp_err_out     = rsp_err_r;
`ifdef APB_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout_out = rsp_timeout_r;
`else
    assign bus.rsp_timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, random transfers
// against a rule-level model, reset mid-ACCESS and (with APB_MASTER_TIMEOUT_EN) timeout.
module tb_apb_master_bridge;

    localparam int TO_CYC = 6;
    localparam int NEVER  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32)) bus ();

    apb_master_bridge #(
        .APB_DATA_WIDTH(32),
        .APB_ADDR_WIDTH(32),
        .TIMEOUT_CYCLE (TO_CYC)
    ) dut (
        .apb_clk_in(clk),
        .apb_rst_in(rst),
        .bus       (bus)
    );

    // Slave model: ready after wait_cfg non-ready ACCESS cycles.
    int          wait_cfg   = 0;
    int          acc_cnt    = 0;
    int          setup_cnt  = 0;
    logic [31:0] rdata_cfg  = 32'h0;
    logic        slverr_cfg = 1'b0;

    assign bus.apb_rdata_in  = rdata_cfg;
    assign bus.apb_slverr_in = slverr_cfg;

    always_comb begin
        bus.apb_ready_in = bus.apb_psel_out && bus.apb_penable_out && (acc_cnt == wait_cfg);
    end

    always @(posedge clk) begin
        if (bus.apb_psel_out && bus.apb_penable_out && !bus.apb_ready_in) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (bus.apb_psel_out && !bus.apb_penable_out) setup_cnt <= setup_cnt + 1;
    end

    int    n_cmp = 0;
    int    n_bad = 0;
    string cur_tag = "reset";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", cur_tag, name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer from IDLE; caller is at a sample point just after a rising edge.
    task automatic run_txn(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input int waits, input logic [31:0] rd,
                           input logic se, input logic [31:0] exp_rd, input logic exp_err,
                           input logic exp_to, input int exp_acc, input int hold);
        int cyc;
        int acc;
        int setups0;
        cur_tag    = tag;
        wait_cfg   = waits;
        rdata_cfg  = rd;
        slverr_cfg = se;
        bus.cmd_write_in = w;
        bus.cmd_addr_in  = a;
        bus.cmd_wdata_in = wd;
        bus.cmd_valid_in = 1'b1;
        setups0 = setup_cnt;
        check("cmd_ready_idle", bus.cmd_ready_out, 1'b1);
        step();
        bus.cmd_valid_in = 1'b0;
        bus.cmd_write_in = ~w;
        bus.cmd_addr_in  = ~a;
        bus.cmd_wdata_in = ~wd;
        check("psel_n1", bus.apb_psel_out, 1'b1);
        check("penable_n1", bus.apb_penable_out, 1'b0);
        check("paddr_setup", bus.apb_addr_out, a);
        cyc = 1;
        acc = 0;
        while (!bus.rsp_valid_out && cyc < 60) begin
            step();
            cyc++;
            if (cyc == 2) check("penable_n2", bus.apb_penable_out, 1'b1);
            if (bus.apb_psel_out && bus.apb_penable_out) begin
                acc++;
                check("paddr_stable", bus.apb_addr_out, a);
                check("pwdata_stable", bus.apb_wdata_out, wd);
                check("pwrite_stable", bus.apb_write_out, w);
            end
        end
        check("latency", cyc, exp_acc + 2);
        check("access_cycles", acc, exp_acc);
        check("rsp_rdata", bus.rsp_rdata_out, exp_rd);
        check("rsp_err", bus.rsp_err_out, exp_err);
        check("rsp_timeout", bus.rsp_timeout_out, exp_to);
        check("psel_resp", bus.apb_psel_out, 1'b0);
        check("penable_resp", bus.apb_penable_out, 1'b0);
        bus.rsp_ready_in = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid_in = 1'b1;
            step();
            check("cmd_ready_hold", bus.cmd_ready_out, 1'b0);
            check("rsp_valid_hold", bus.rsp_valid_out, 1'b1);
            check("rsp_rdata_hold", bus.rsp_rdata_out, exp_rd);
            check("rsp_err_hold", bus.rsp_err_out, exp_err);
            check("rsp_timeout_hold", bus.rsp_timeout_out, exp_to);
        end
        bus.cmd_valid_in = 1'b0;
        bus.rsp_ready_in = 1'b1;
        step();
        bus.rsp_ready_in = 1'b0;
        check("rsp_valid_done", bus.rsp_valid_out, 1'b0);
        check("cmd_ready_done", bus.cmd_ready_out, 1'b1);
        check("one_transfer", setup_cnt - setups0, 1);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        int          waits;
        logic [31:0] rd;
        logic        se;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_acc;
        int          hold;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic        rw;
        logic [31:0] ra, rwd, rrd;
        logic        rse;
        int          rwt, rh;

        vt[0] = '{1'b0, 32'hA030_0004, 32'h0000_0000, 0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1, 0};
        vt[1] = '{1'b1, 32'hA030_0000, 32'hDEAD_BEEF, 3, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b0, 4, 0};
        vt[2] = '{1'b0, 32'hA030_0008, 32'h0000_0000, 1, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1, 2, 1};
        vt[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 0, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1, 5};
        vt[4] = '{1'b1, 32'h0000_0020, 32'h0000_0001, 5, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 6, 2};

        bus.cmd_valid_in = 1'b0;
        bus.cmd_write_in = 1'b0;
        bus.cmd_addr_in  = 32'h0;
        bus.cmd_wdata_in = 32'h0;
        bus.rsp_ready_in = 1'b0;

        // Reset values
        bus.cmd_valid_in = 1'b1;
        bus.cmd_addr_in  = 32'hFFFF_FFFF;
        repeat (3) step();
        check("psel", bus.apb_psel_out, 1'b0);
        check("penable", bus.apb_penable_out, 1'b0);
        check("pwrite", bus.apb_write_out, 1'b0);
        check("paddr", bus.apb_addr_out, 32'h0);
        check("pwdata", bus.apb_wdata_out, 32'h0);
        check("rsp_valid", bus.rsp_valid_out, 1'b0);
        check("rsp_rdata", bus.rsp_rdata_out, 32'h0);
        check("rsp_err", bus.rsp_err_out, 1'b0);
        check("rsp_timeout", bus.rsp_timeout_out, 1'b0);
        bus.cmd_valid_in = 1'b0;
        rst = 1'b0;
        step();
        check("cmd_ready_after_reset", bus.cmd_ready_out, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].wd, vt[i].waits, vt[i].rd,
                    vt[i].se, vt[i].exp_rd, vt[i].exp_err, 1'b0, vt[i].exp_acc, vt[i].hold);
        end

        // Random transfers: expected result follows directly from the transfer rules.
        for (int i = 0; i < 24; i++) begin
            rw  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rwd = $urandom;
            rrd = $urandom;
            rse = ($urandom_range(0, 3) == 0);
            rwt = $urandom_range(0, 3);
            rh  = $urandom_range(0, 3);
            run_txn($sformatf("rnd%0d", i), rw, ra, rwd, rwt, rrd, rse,
                    rw ? 32'h0 : rrd, rse, 1'b0, rwt + 1, rh);
        end

        // Reset in the second ACCESS cycle aborts without a response.
        cur_tag = "reset_mid_access";
        wait_cfg = NEVER;
        bus.cmd_write_in = 1'b0;
        bus.cmd_addr_in  = 32'hA030_0010;
        bus.cmd_valid_in = 1'b1;
        step();
        bus.cmd_valid_in = 1'b0;
        step();
        step();
        check("in_access", bus.apb_penable_out, 1'b1);
        rst = 1'b1;
        step();
        check("psel", bus.apb_psel_out, 1'b0);
        check("penable", bus.apb_penable_out, 1'b0);
        check("rsp_valid", bus.rsp_valid_out, 1'b0);
        check("cmd_ready", bus.cmd_ready_out, 1'b1);
        rst = 1'b0;
        step();
        check("cmd_ready_post", bus.cmd_ready_out, 1'b1);
        check("rsp_valid_post", bus.rsp_valid_out, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
        run_txn("timeout", 1'b0, 32'hA030_0020, 32'h0, NEVER, 32'h5555_5555, 1'b0,
                32'h0, 1'b1, 1'b1, TO_CYC, 1);
`endif
        run_txn("after", 1'b0, 32'h0000_0040, 32'h0, 0, 32'h7777_0001, 1'b0,
                32'h7777_0001, 1'b0, 1'b0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
